// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running line/frame counters, sync decode and a
// pixel request window one clock ahead of the active area to cover generator latency.
module vga_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 40,
   parameter int H_LEFT   = 8,
   parameter int H_VALID  = 640,
   parameter int H_RIGHT  = 8,
   parameter int H_FRONT  = 8,
   parameter int H_TOTAL  = 800,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 25,
   parameter int V_TOP    = 8,
   parameter int V_VALID  = 480,
   parameter int V_BOTTOM = 8,
   parameter int V_FRONT  = 2,
   parameter int V_TOTAL  = 525
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] rgb,
   output logic        frame_start
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SW   = 10'(H_SYNC);
   localparam logic [9:0] V_SW   = 10'(V_SYNC);
   localparam logic [9:0] HS     = 10'(H_SYNC + H_BACK + H_LEFT);
   localparam logic [9:0] HE     = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
   localparam logic [9:0] VS     = 10'(V_SYNC + V_BACK + V_TOP);
   localparam logic [9:0] VE     = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);

   // Catch inconsistent timing tables at elaboration.
   if (H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT != H_TOTAL) begin : g_h_bad
      $error("vga_ctrl: horizontal fields do not sum to H_TOTAL");
   end
   if (V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT != V_TOTAL) begin : g_v_bad
      $error("vga_ctrl: vertical fields do not sum to V_TOTAL");
   end

   logic [9:0] cnt_h;
   logic [9:0] cnt_v;
   logic       v_act;
   logic       rgb_valid;
   logic       pix_data_req;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h       <= '0;
         cnt_v       <= '0;
         frame_start <= 1'b0;
      end else begin
         cnt_h <= (cnt_h == H_LAST) ? 10'd0 : cnt_h + 10'd1;
         if (cnt_h == H_LAST)
            cnt_v <= (cnt_v == V_LAST) ? 10'd0 : cnt_v + 10'd1;
         // Registered so it is high exactly while the counters sit at (0,0).
         frame_start <= (cnt_h == H_LAST) && (cnt_v == V_LAST);
      end
   end

   always_comb begin
      hsync        = cnt_h < H_SW;
      vsync        = cnt_v < V_SW;
      v_act        = (cnt_v >= VS) && (cnt_v < VE);
      rgb_valid    = v_act && (cnt_h >= HS) && (cnt_h < HE);
      pix_data_req = v_act && (cnt_h >= HS - 10'd1) && (cnt_h < HE - 10'd1);
      // Subtract only inside the window so no wrapped value leaks out.
      pix_x        = pix_data_req ? cnt_h - (HS - 10'd1) : 10'h3FF;
      pix_y        = pix_data_req ? cnt_v - VS : 10'h3FF;
      rgb          = rgb_valid ? pix_data : 16'h0000;
   end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with shrunken timing; checks outputs against a
// position-based model (edge count -> line/column) and a vector table.
module tb_vga_ctrl;

   localparam int HSY = 4, HBK = 2, HLF = 1, HVL = 8, HRT = 1, HFR = 2, HT = 18;
   localparam int VSY = 2, VBK = 1, VTP = 1, VVL = 4, VBT = 1, VFR = 1, VT = 10;
   localparam int HS = HSY + HBK + HLF;
   localparam int VS = VSY + VBK + VTP;
   localparam int FRAME = HT * VT;

   logic        vga_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] drv_data = 16'h0;
   logic [15:0] gen_reg;
   logic        gen_mode = 1'b0;
   logic [15:0] pix_data;
   logic [9:0]  pix_x, pix_y;
   logic        hsync, vsync, frame_start;
   logic [15:0] rgb;

   int total = 0;
   int bad = 0;
   int t = 0;

   vga_ctrl #(
      .H_SYNC(HSY), .H_BACK(HBK), .H_LEFT(HLF), .H_VALID(HVL), .H_RIGHT(HRT),
      .H_FRONT(HFR), .H_TOTAL(HT),
      .V_SYNC(VSY), .V_BACK(VBK), .V_TOP(VTP), .V_VALID(VVL), .V_BOTTOM(VBT),
      .V_FRONT(VFR), .V_TOTAL(VT)
   ) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
      .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
      .rgb(rgb), .frame_start(frame_start)
   );

   always #5 vga_clk = ~vga_clk;

   // Picture generator stand-in: registered coordinate tag.
   always @(posedge vga_clk) gen_reg <= {pix_y[5:0], pix_x};
   assign pix_data = gen_mode ? gen_reg : drv_data;

   typedef struct {
      int          h;
      int          v;
      logic [15:0] pd;
      logic        hs;
      logic        vs;
      logic [9:0]  px;
      logic [9:0]  py;
      logic [15:0] rg;
      logic        fs;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
      end
   endtask

   // One clock: t counts rising edges seen out of reset; ends at the falling edge.
   task automatic step();
      @(posedge vga_clk);
      if (sys_rst_n) t++;
      @(negedge vga_clk);
   endtask

   task automatic check_model();
      int pos, h, v;
      bit req, val;
      logic [15:0] exp_rgb;
      pos = t % FRAME;
      h = pos % HT;
      v = pos / HT;
      req = (v >= VS) && (v < VS + VVL) && (h >= HS - 1) && (h < HS + HVL - 1);
      val = (v >= VS) && (v < VS + VVL) && (h >= HS) && (h < HS + HVL);
      if (!val) exp_rgb = 16'h0;
      else if (gen_mode) exp_rgb = 16'((((v - VS) & 63) << 10) | (h - HS));
      else exp_rgb = drv_data;
      chk("hsync", 32'(hsync), 32'(h < HSY));
      chk("vsync", 32'(vsync), 32'(v < VSY));
      chk("pix_x", 32'(pix_x), req ? 32'(h - (HS - 1)) : 32'h3FF);
      chk("pix_y", 32'(pix_y), req ? 32'(v - VS) : 32'h3FF);
      chk("rgb", 32'(rgb), 32'(exp_rgb));
      chk("frame_start", 32'(frame_start), 32'(t > 0 && pos == 0));
   endtask

   initial begin
      int base, n, cnt_ff, cnt_fs;
      tbl[0]  = '{0,  0, 16'h0000, 1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1};
      tbl[1]  = '{3,  1, 16'h0000, 1, 1, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[2]  = '{4,  1, 16'h0000, 0, 1, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[3]  = '{4,  2, 16'h0000, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[4]  = '{10, 3, 16'hFFFF, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[5]  = '{6,  4, 16'h1234, 0, 0, 10'd0,   10'd0,   16'h0000, 0};
      tbl[6]  = '{7,  4, 16'hABCD, 0, 0, 10'd1,   10'd0,   16'hABCD, 0};
      tbl[7]  = '{13, 5, 16'h5555, 0, 0, 10'd7,   10'd1,   16'h5555, 0};
      tbl[8]  = '{14, 5, 16'h7777, 0, 0, 10'h3FF, 10'h3FF, 16'h7777, 0};
      tbl[9]  = '{15, 5, 16'h7777, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[10] = '{10, 7, 16'hFFFF, 0, 0, 10'd4,   10'd3,   16'hFFFF, 0};
      tbl[11] = '{10, 8, 16'hFFFF, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0};
      tbl[12] = '{17, 9, 16'h0000, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0};

      // Reset held across several edges: counters must not move.
      drv_data = 16'hBEEF;
      repeat (3) step();
      #1 check_model();
      sys_rst_n = 1'b1;

      // Random pixel data over two frames.
      repeat (2 * FRAME) begin
         step();
         drv_data = 16'($urandom);
         #1 check_model();
      end

      // Vector table, frame 2 (t already at its first clock).
      base = 2 * FRAME;
      for (int i = 0; i < 13; i++) begin
         while (t < base + tbl[i].v * HT + tbl[i].h) step();
         drv_data = tbl[i].pd;
         #1;
         chk($sformatf("tbl%0d_hsync", i), 32'(hsync), 32'(tbl[i].hs));
         chk($sformatf("tbl%0d_vsync", i), 32'(vsync), 32'(tbl[i].vs));
         chk($sformatf("tbl%0d_pix_x", i), 32'(pix_x), 32'(tbl[i].px));
         chk($sformatf("tbl%0d_pix_y", i), 32'(pix_y), 32'(tbl[i].py));
         chk($sformatf("tbl%0d_rgb", i), 32'(rgb), 32'(tbl[i].rg));
         chk($sformatf("tbl%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
      end

      // Constant white: lit clocks per frame must equal the active area.
      while (t % FRAME != 0) step();
      drv_data = 16'hFFFF;
      cnt_ff = 0;
      cnt_fs = 0;
      for (int i = 0; i < FRAME; i++) begin
         #1;
         if (rgb == 16'hFFFF) cnt_ff++;
         if (frame_start) cnt_fs++;
         step();
      end
      chk("white_count", 32'(cnt_ff), 32'(HVL * VVL));
      chk("fs_per_frame", 32'(cnt_fs), 32'd1);

      // Registered coordinate-tag generator: end-to-end one-clock latency.
      gen_mode = 1'b1;
      repeat (FRAME) begin
         step();
         #1 check_model();
      end
      gen_mode = 1'b0;

      // Asynchronous reset mid-frame.
      while (t % FRAME != 5 * HT + 9) step();
      drv_data = 16'h5A5A;
      #1 check_model();
      sys_rst_n = 1'b0;
      #1;
      chk("arst_hsync", 32'(hsync), 32'd1);
      chk("arst_vsync", 32'(vsync), 32'd1);
      chk("arst_pix_x", 32'(pix_x), 32'h3FF);
      chk("arst_pix_y", 32'(pix_y), 32'h3FF);
      chk("arst_rgb", 32'(rgb), 32'h0);
      chk("arst_fs", 32'(frame_start), 32'd0);
      repeat (3) step();
      t = 0;
      #1 check_model();
      sys_rst_n = 1'b1;
      n = 0;
      while (!frame_start && n < 2 * FRAME) begin
         step();
         n++;
         #1;
      end
      chk("fs_after_reset", 32'(n), 32'(FRAME));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
